// File: rtl/matriz_seta_animada.sv
// Scanned LED-matrix arrow driver: column multiplexing, up/down scrolling arrow
// and emergency blink, all synchronous to a single clock.
module matriz_seta_animada #(
   parameter int NUM_COLS  = 5,
   parameter int NUM_ROWS  = 7,
   parameter int SCAN_DIV  = 1000,
   parameter int FRAME_DIV = 50
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [1:0]          direcao,
   input  logic                animar,
   output logic [NUM_COLS-1:0] colunas,
   output logic [NUM_ROWS-1:0] linhas,
   output logic                quadro_fim
);

   localparam int SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
   localparam int COL_W   = (NUM_COLS  > 1) ? $clog2(NUM_COLS)  : 1;
   localparam int FRAME_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
   localparam int ROW_W   = (NUM_ROWS  > 1) ? $clog2(NUM_ROWS)  : 1;
   localparam int CENTER  = (NUM_COLS - 1) / 2;

   localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
   localparam logic [COL_W-1:0]   COL_LAST   = COL_W'(NUM_COLS - 1);
   localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(FRAME_DIV - 1);
   localparam logic [ROW_W-1:0]   ROW_LAST   = ROW_W'(NUM_ROWS - 1);

   typedef enum logic [1:0] {
      PARADO     = 2'b00,
      SUBINDO    = 2'b01,
      DESCENDO   = 2'b10,
      EMERGENCIA = 2'b11
   } modo_t;

   logic [SCAN_W-1:0]   scan_cnt_q,   scan_cnt_d;
   logic [COL_W-1:0]    col_idx_q,    col_idx_d;
   logic [FRAME_W-1:0]  frame_cnt_q,  frame_cnt_d;
   logic [ROW_W-1:0]    offset_q,     offset_d;
   logic                blink_q,      blink_d;
   modo_t               modo_q,       modo_d;
   logic [NUM_COLS-1:0] colunas_q,    colunas_d;
   logic [NUM_ROWS-1:0] linhas_q,     linhas_d;
   logic                quadro_fim_q, quadro_fim_d;

   logic scan_fim;
   logic col_fim;
   logic frame_tick;
   logic modo_muda;
   logic anima_ativa;

   // Arrow shape: a triangle head over the top C+1 rows, a one-column shaft below.
   function automatic logic pixel_aceso(input int p, input int col);
      int d;
      d = (col >= CENTER) ? (col - CENTER) : (CENTER - col);
      if (p <= CENTER) begin
         return (d <= p);
      end
      return (d == 0);
   endfunction

   // Source pattern row for display row r; the sum stays below 2*NUM_ROWS,
   // so a single conditional subtract is an exact modulo.
   function automatic int linha_fonte(input int r, input int off, input logic desce);
      int s;
      s = (desce ? (NUM_ROWS - 1 - r) : r) + off;
      if (s >= NUM_ROWS) begin
         s = s - NUM_ROWS;
      end
      return s;
   endfunction

   always_comb begin
      scan_fim   = (scan_cnt_q == SCAN_LAST);
      col_fim    = scan_fim && (col_idx_q == COL_LAST);
      frame_tick = col_fim && (frame_cnt_q == FRAME_LAST);

      scan_cnt_d = scan_fim ? '0 : scan_cnt_q + 1'b1;

      col_idx_d = col_idx_q;
      if (scan_fim) begin
         col_idx_d = (col_idx_q == COL_LAST) ? '0 : col_idx_q + 1'b1;
      end

      frame_cnt_d = frame_cnt_q;
      if (col_fim) begin
         frame_cnt_d = (frame_cnt_q == FRAME_LAST) ? '0 : frame_cnt_q + 1'b1;
      end
   end

   // A mode change clears the animation state even when it lands on a frame tick.
   always_comb begin
      modo_d      = modo_t'(direcao);
      modo_muda   = (modo_d != modo_q);
      anima_ativa = animar && ((modo_q == SUBINDO) || (modo_q == DESCENDO));

      offset_d = offset_q;
      if (modo_muda || !anima_ativa) begin
         offset_d = '0;
      end else if (frame_tick) begin
         offset_d = (offset_q == ROW_LAST) ? '0 : offset_q + 1'b1;
      end

      blink_d = blink_q;
      if (modo_muda || (modo_q != EMERGENCIA)) begin
         blink_d = 1'b0;
      end else if (frame_tick) begin
         blink_d = ~blink_q;
      end
   end

   always_comb begin
      colunas_d            = '0;
      colunas_d[col_idx_q] = 1'b1;

      linhas_d = '1;
      case (modo_q)
         SUBINDO, DESCENDO: begin
            for (int r = 0; r < NUM_ROWS; r++) begin
               linhas_d[r] = ~pixel_aceso(
                  linha_fonte(r, int'(offset_q), modo_q == DESCENDO),
                  int'(col_idx_q));
            end
         end
         EMERGENCIA: linhas_d = {NUM_ROWS{blink_q}};
         default:    linhas_d = '1;
      endcase

      quadro_fim_d = frame_tick;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         scan_cnt_q   <= '0;
         col_idx_q    <= '0;
         frame_cnt_q  <= '0;
         offset_q     <= '0;
         blink_q      <= 1'b0;
         modo_q       <= PARADO;
         colunas_q    <= '0;
         linhas_q     <= '1;
         quadro_fim_q <= 1'b0;
      end else begin
         scan_cnt_q   <= scan_cnt_d;
         col_idx_q    <= col_idx_d;
         frame_cnt_q  <= frame_cnt_d;
         offset_q     <= offset_d;
         blink_q      <= blink_d;
         modo_q       <= modo_d;
         colunas_q    <= colunas_d;
         linhas_q     <= linhas_d;
         quadro_fim_q <= quadro_fim_d;
      end
   end

   assign colunas    = colunas_q;
   assign linhas     = linhas_q;
   assign quadro_fim = quadro_fim_q;

endmodule

// File: tb/tb_matriz_seta_animada.sv
// Bench for matriz_seta_animada with 5x7 matrix, SCAN_DIV=2, FRAME_DIV=2:
// static-pattern vector table plus directed animation, blink and reset sequences.
`timescale 1ns/1ps
module tb_matriz_seta_animada;

   localparam int NC = 5;
   localparam int NR = 7;

   logic          clock   = 1'b0;
   logic          reset   = 1'b1;
   logic [1:0]    direcao = 2'b00;
   logic          animar  = 1'b0;
   logic [NC-1:0] colunas;
   logic [NR-1:0] linhas;
   logic          quadro_fim;

   int   n_checks = 0;
   int   n_pass   = 0;
   logic rst_prev = 1'b1;

   typedef struct {
      logic [1:0]    dir;
      logic          anim;
      int            col;
      logic [NR-1:0] linhas;
   } vec_t;

   typedef struct {
      int            col;
      logic [NR-1:0] linhas;
      string         nm;
   } sb_t;

   vec_t tbl[15];
   sb_t  sb_q[$];
   sb_t  sb_e;

   matriz_seta_animada #(
      .NUM_COLS (NC),
      .NUM_ROWS (NR),
      .SCAN_DIV (2),
      .FRAME_DIV(2)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .direcao   (direcao),
      .animar    (animar),
      .colunas   (colunas),
      .linhas    (linhas),
      .quadro_fim(quadro_fim)
   );

   always #5 clock = ~clock;

   always @(posedge clock) rst_prev <= reset;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
   endtask

   task automatic push(input int col, input logic [NR-1:0] l, input string nm);
      sb_t e;
      e.col    = col;
      e.linhas = l;
      e.nm     = nm;
      sb_q.push_back(e);
   endtask

   task automatic settle(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic wait_pulse(output int n);
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (!quadro_fim && n < 100);
      if (!quadro_fim) begin
         n_checks++;
         $display("FAIL pulse_wait: no quadro_fim within %0d cycles, required a pulse", n);
      end
   endtask

   task automatic wait_sb(input string nm);
      for (int i = 0; i < 40 && sb_q.size() > 0; i++) @(negedge clock);
      if (sb_q.size() > 0) begin
         n_checks++;
         $display("FAIL %s: %0d expected column(s) never shown, required 0 pending", nm, sb_q.size());
         sb_q.delete();
      end
   endtask

   // Scoreboard consumer: pops an entry when its column is on the bus.
   always @(negedge clock) begin
      if (!rst_prev) begin
         chk("colunas_onehot", {31'd0, $onehot(colunas)}, 32'd1);
         if (sb_q.size() > 0 && colunas == NC'(1 << sb_q[0].col)) begin
            sb_e = sb_q.pop_front();
            chk(sb_e.nm, 32'(linhas), 32'(sb_e.linhas));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1);
   end

   initial begin
      int n;
      tbl[0]  = '{2'b01, 1'b0, 0, 7'b1111011};
      tbl[1]  = '{2'b01, 1'b0, 1, 7'b1111001};
      tbl[2]  = '{2'b01, 1'b0, 2, 7'b0000000};
      tbl[3]  = '{2'b01, 1'b0, 3, 7'b1111001};
      tbl[4]  = '{2'b01, 1'b0, 4, 7'b1111011};
      tbl[5]  = '{2'b10, 1'b0, 0, 7'b1101111};
      tbl[6]  = '{2'b10, 1'b0, 1, 7'b1001111};
      tbl[7]  = '{2'b10, 1'b0, 2, 7'b0000000};
      tbl[8]  = '{2'b10, 1'b0, 3, 7'b1001111};
      tbl[9]  = '{2'b10, 1'b0, 4, 7'b1101111};
      tbl[10] = '{2'b00, 1'b0, 0, 7'b1111111};
      tbl[11] = '{2'b00, 1'b0, 1, 7'b1111111};
      tbl[12] = '{2'b00, 1'b0, 2, 7'b1111111};
      tbl[13] = '{2'b00, 1'b0, 3, 7'b1111111};
      tbl[14] = '{2'b00, 1'b0, 4, 7'b1111111};

      // Reset hold, release, column dwell and first frame pulse timing
      repeat (3) @(negedge clock);
      chk("rst_colunas", 32'(colunas), 32'h0);
      chk("rst_linhas", 32'(linhas), 32'h7f);
      chk("rst_quadro", 32'(quadro_fim), 32'h0);
      reset = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clock);
         if (k <= 10) chk($sformatf("scan_col_k%0d", k), 32'(colunas), 32'(1 << ((k - 1) / 2)));
         if (k == 19) chk("quadro_before_first", 32'(quadro_fim), 32'h0);
         if (k == 20) chk("quadro_first", 32'(quadro_fim), 32'h1);
      end

      // Static patterns, twice so frame ticks pass in between
      for (int pass = 0; pass < 2; pass++) begin
         for (int i = 0; i < 15; i++) begin
            direcao = tbl[i].dir;
            animar  = tbl[i].anim;
            settle(3);
            push(tbl[i].col, tbl[i].linhas, $sformatf("tbl%0d_pass%0d", i, pass));
            wait_sb("tbl_sb");
         end
      end

      // Upward scrolling
      direcao = 2'b01;
      animar  = 1'b1;
      settle(1);
      wait_pulse(n);
      push(1, 7'b1111100, "sub_off1_col1");
      wait_pulse(n);
      chk("quadro_period", n, 20);
      wait_sb("sub_off1_sb");
      push(1, 7'b0111110, "sub_off2_col1");
      @(negedge clock);
      chk("quadro_width", 32'(quadro_fim), 32'h0);
      wait_pulse(n);
      chk("quadro_period2", n, 19);
      wait_sb("sub_off2_sb");
      repeat (4) wait_pulse(n);
      push(0, 7'b1111011, "sub_off7_col0");
      push(1, 7'b1111001, "sub_off7_col1");
      push(2, 7'b0000000, "sub_off7_col2");
      wait_sb("sub_off7_sb");

      // Mode change landing exactly on a frame tick: offset must stay 0
      wait_pulse(n);
      repeat (19) @(negedge clock);
      direcao = 2'b10;
      wait_pulse(n);
      chk("quadro_on_switch", n, 1);
      push(0, 7'b1101111, "coinc_col0");
      push(1, 7'b1001111, "coinc_col1");
      wait_sb("coinc_sb");

      // subindo at offset 3, then switch to descendo
      direcao = 2'b01;
      settle(1);
      repeat (3) wait_pulse(n);
      push(1, 7'b0011111, "sub_off3_col1");
      wait_sb("sub_off3_sb");
      direcao = 2'b10;
      settle(2);
      push(0, 7'b1101111, "switch_desc_col0");
      push(1, 7'b1001111, "switch_desc_col1");
      push(2, 7'b0000000, "switch_desc_col2");
      wait_sb("switch_sb");

      // Emergency blink
      direcao = 2'b11;
      animar  = 1'b0;
      settle(1);
      wait_pulse(n);
      chk("emerg_entry", 32'(linhas), 32'h00);
      for (int ph = 0; ph < 3; ph++) begin
         for (int i = 1; i <= 20; i++) begin
            @(negedge clock);
            chk($sformatf("emerg_ph%0d_c%0d", ph, i), 32'(linhas), (ph % 2 == 0) ? 32'h7f : 32'h00);
            if (i == 20) chk($sformatf("emerg_quadro_ph%0d", ph), 32'(quadro_fim), 32'h1);
         end
      end

      // Reset in the middle of an animated sweep
      direcao = 2'b01;
      animar  = 1'b1;
      settle(1);
      repeat (2) wait_pulse(n);
      repeat (5) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      chk("midrst_colunas", 32'(colunas), 32'h0);
      chk("midrst_linhas", 32'(linhas), 32'h7f);
      chk("midrst_quadro", 32'(quadro_fim), 32'h0);
      reset = 1'b0;
      @(negedge clock);
      chk("rel_col0", 32'(colunas), 32'h1);
      push(1, 7'b1111001, "rel_off0_col1");
      wait_pulse(n);
      chk("rel_first_quadro", n, 19);
      wait_sb("rel_sb");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
